// File: rtl/stream_max_argmax_if.sv
// Element input and frame-result output of the streaming max/argmax finder.
// The slave modport is the finder's side; master is the producer/consumer side.
interface stream_max_argmax_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned SIZE  = 3
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_max;
  logic [SIZE-1:0]  out_argmax;
  logic [SIZE:0]    out_len;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_max, out_argmax, out_len
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_max, out_argmax, out_len
  );
endinterface

// File: rtl/stream_max_argmax.sv
// Streaming max/argmax: one element per accepted beat, frame result held on a
// valid/ready port. Unsigned compare; ties resolve to the last index.
module stream_max_argmax #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned SIZE  = 3
) (
  input logic               clk,
  input logic               rst_n,
  stream_max_argmax_if.slave bus
);

  localparam logic [0:0]    StAccum = 1'b0;
  localparam logic [0:0]    StDone  = 1'b1;
  localparam logic [SIZE:0] LastIdx = (SIZE+1)'((1 << SIZE) - 1);

  logic [0:0]       state_q, state_d;
  logic [SIZE:0]    idx_q, idx_d;
  logic [WIDTH-1:0] run_max_q, run_max_d;
  logic [SIZE-1:0]  run_arg_q, run_arg_d;
  logic [WIDTH-1:0] out_max_q, out_max_d;
  logic [SIZE-1:0]  out_arg_q, out_arg_d;
  logic [SIZE:0]    out_len_q, out_len_d;

  logic             accept;
  logic             take;
  logic             close;
  logic [WIDTH-1:0] cand_max;
  logic [SIZE-1:0]  cand_arg;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    run_max_d = run_max_q;
    run_arg_d = run_arg_q;
    out_max_d = out_max_q;
    out_arg_d = out_arg_q;
    out_len_d = out_len_q;

    accept = (state_q == StAccum) && bus.in_valid;
    // First element of a frame seeds the running max; ">=" makes ties move to the later index.
    take     = (idx_q == '0) || (bus.in_data >= run_max_q);
    cand_max = take ? bus.in_data : run_max_q;
    cand_arg = take ? idx_q[SIZE-1:0] : run_arg_q;
    close    = bus.in_last || (idx_q == LastIdx);

    case (state_q)
      StAccum: begin
        if (accept) begin
          if (close) begin
            state_d   = StDone;
            out_max_d = cand_max;
            out_arg_d = cand_arg;
            out_len_d = idx_q + (SIZE+1)'(1);
            idx_d     = '0;
          end else begin
            run_max_d = cand_max;
            run_arg_d = cand_arg;
            idx_d     = idx_q + (SIZE+1)'(1);
          end
        end
      end
      StDone: begin
        if (bus.out_ready) begin
          state_d = StAccum;
        end
      end
      default: state_d = StAccum;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StAccum;
      idx_q     <= '0;
      run_max_q <= '0;
      run_arg_q <= '0;
      out_max_q <= '0;
      out_arg_q <= '0;
      out_len_q <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      run_max_q <= run_max_d;
      run_arg_q <= run_arg_d;
      out_max_q <= out_max_d;
      out_arg_q <= out_arg_d;
      out_len_q <= out_len_d;
    end
  end

  assign bus.in_ready   = (state_q == StAccum);
  assign bus.out_valid  = (state_q == StDone);
  assign bus.out_max    = out_max_q;
  assign bus.out_argmax = out_arg_q;
  assign bus.out_len    = out_len_q;

endmodule

// File: tb/tb_stream_max_argmax.sv
// Bench for stream_max_argmax: directed and random frames, a frame-level
// reference model feeding a scoreboard, and an independent output monitor.
module tb_stream_max_argmax;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned SIZE  = 3;
  localparam int unsigned N     = 1 << SIZE;

  typedef struct {
    int unsigned mx;
    int unsigned arg;
    int unsigned len;
  } exp_t;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  int   rdy_mode;  // 0: always ready, 1: hold off, 2: random

  exp_t        sb[$];
  int unsigned cur[$];
  int unsigned frame_q[$];

  stream_max_argmax_if #(.WIDTH(WIDTH), .SIZE(SIZE)) bus ();

  stream_max_argmax #(.WIDTH(WIDTH), .SIZE(SIZE)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: a frame ends on in_last or on its N-th element; the result is the
  // largest value and the highest index holding it.
  task automatic model_beat(input int unsigned d, input bit l);
    exp_t e;
    cur.push_back(d);
    if (l || cur.size() == N) begin
      e.mx = 0;
      foreach (cur[i]) if (cur[i] > e.mx) e.mx = cur[i];
      e.arg = 0;
      foreach (cur[i]) if (cur[i] == e.mx) e.arg = i;
      e.len = cur.size();
      sb.push_back(e);
      cur.delete();
      chk("latency_out_valid", {31'd0, bus.out_valid}, 32'd1);
    end
  endtask

  task automatic send_beat(input int unsigned d, input bit l);
    int  n;
    bit  ok;
    n  = 0;
    ok = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d[WIDTH-1:0];
    bus.in_last  = l;
    while (!ok && n < 200) begin
      @(negedge clk);
      if (bus.in_ready) begin
        @(posedge clk);
        #1;
        ok = 1;
      end else begin
        n++;
      end
    end
    bus.in_valid = 1'b0;
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: got no in_ready expected in_ready within 200 cycles");
    end else begin
      model_beat(d, l);
    end
  endtask

  task automatic idle(input int cycles);
    repeat (cycles) begin
      @(posedge clk);
      #1;
    end
  endtask

  // bubble: 0 none, 1 one idle cycle after each beat, 2 random 0..2 idle cycles
  task automatic send_frame(input bit use_last, input int bubble);
    int sz;
    sz = frame_q.size();
    for (int i = 0; i < sz; i++) begin
      send_beat(frame_q[i], use_last && (i == sz - 1));
      if (bubble == 1) idle(1);
      else if (bubble == 2) idle(int'($urandom_range(0, 2)));
    end
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (sb.size() > 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (sb.size() > 0) begin
      bad++;
      $display("FAIL %s: got %0d pending results expected 0", name, sb.size());
    end
  endtask

  // Consumer: out_ready changes just after the rising edge.
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      case (rdy_mode)
        0:       bus.out_ready = 1'b1;
        1:       bus.out_ready = 1'b0;
        default: bus.out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: pops the scoreboard on each result handshake, checks hold stability.
  initial begin
    bit          hold;
    int unsigned p_max, p_arg, p_len;
    exp_t        e;
    hold = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        hold = 0;
        continue;
      end
      total++;
      if (bus.in_ready !== !bus.out_valid) begin
        bad++;
        $display("FAIL in_ready_vs_out_valid: got in_ready=%b expected %b", bus.in_ready,
                 !bus.out_valid);
      end
      if (hold) begin
        total++;
        if (bus.out_valid !== 1'b1 || bus.out_max != p_max || bus.out_argmax != p_arg ||
            bus.out_len != p_len) begin
          bad++;
          $display("FAIL hold_stable: got v=%b max=%0d arg=%0d len=%0d expected v=1 max=%0d arg=%0d len=%0d",
                   bus.out_valid, bus.out_max, bus.out_argmax, bus.out_len, p_max, p_arg, p_len);
        end
      end
      hold = 0;
      if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL unexpected_result: got max=%0d arg=%0d len=%0d expected no result",
                   bus.out_max, bus.out_argmax, bus.out_len);
        end else begin
          e = sb.pop_front();
          if (bus.out_max != e.mx || bus.out_argmax != e.arg || bus.out_len != e.len) begin
            bad++;
            $display("FAIL result: got max=%0d arg=%0d len=%0d expected max=%0d arg=%0d len=%0d",
                     bus.out_max, bus.out_argmax, bus.out_len, e.mx, e.arg, e.len);
          end
        end
      end else if (bus.out_valid === 1'b1) begin
        hold  = 1;
        p_max = bus.out_max;
        p_arg = bus.out_argmax;
        p_len = bus.out_len;
      end
    end
  end

  initial begin
    total        = 0;
    bad          = 0;
    rdy_mode     = 0;
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.in_last  = 1'b0;
    idle(3);
    chk("reset_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("reset_in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("reset_out_max", {24'd0, bus.out_max}, 32'd0);
    chk("reset_out_argmax", {29'd0, bus.out_argmax}, 32'd0);
    chk("reset_out_len", {28'd0, bus.out_len}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(1);

    // Full frame closed by element count
    frame_q = '{10, 20, 30, 40, 50, 60, 70, 80};
    send_frame(0, 0);
    // Ties, all-equal (in_last on the N-th beat), extremes
    frame_q = '{50, 30, 80, 20, 80, 10, 80, 40};
    send_frame(0, 0);
    frame_q = '{42, 42, 42, 42, 42, 42, 42, 42};
    send_frame(1, 0);
    frame_q = '{0, 255, 0, 128, 255, 0, 255, 1};
    send_frame(0, 0);
    // Short frames
    frame_q = '{5, 90, 7};
    send_frame(1, 0);
    frame_q = '{3, 3};
    send_frame(1, 0);
    drain("drain_directed");

    // Back-pressure: result held, offered beats ignored
    rdy_mode = 1;
    idle(2);
    frame_q = '{9, 200, 17, 4};
    send_frame(1, 0);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'd250;
    bus.in_last  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_in_ready_low", {31'd0, bus.in_ready}, 32'd0);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    rdy_mode = 0;
    frame_q = '{1, 2, 3};
    send_frame(1, 0);

    // Bubbles between every beat
    frame_q = '{80, 70, 60, 50, 40, 30, 20, 10};
    send_frame(0, 1);
    drain("drain_bp_bubbles");

    // Reset mid-frame discards the partial frame
    frame_q = '{10, 20, 99, 50};
    send_frame(0, 0);
    rst_n = 1'b0;
    #2;
    chk("midreset_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("midreset_out_max", {24'd0, bus.out_max}, 32'd0);
    chk("midreset_out_argmax", {29'd0, bus.out_argmax}, 32'd0);
    chk("midreset_out_len", {28'd0, bus.out_len}, 32'd0);
    chk("midreset_in_ready", {31'd0, bus.in_ready}, 32'd1);
    cur.delete();
    @(negedge clk);
    rst_n = 1'b1;
    idle(1);
    frame_q = '{1, 2, 3, 4, 5, 6, 7, 8};
    send_frame(0, 0);
    drain("drain_reset");

    // Random frames, gaps and consumer stalls
    rdy_mode = 2;
    for (int f = 0; f < 40; f++) begin
      int len;
      bit narrow;
      len    = int'($urandom_range(1, N));
      narrow = 1'($urandom_range(0, 1));
      frame_q.delete();
      for (int i = 0; i < len; i++)
        frame_q.push_back(narrow ? $urandom_range(0, 3) : $urandom_range(0, 255));
      send_frame((len < int'(N)) ? 1'b1 : 1'($urandom_range(0, 1)), 2);
    end
    rdy_mode = 0;
    drain("drain_random");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
